friscv_dispatcher: RTL and testbench
====================================

FRISCV_DISPATCHER -- requirements
Module: friscv_dispatcher

Interface
REQ-001 SHALL have parameter INST_W, default 128: instruction bus width.
REQ-002 SHALL have parameter NB_UNIT, default 3: execution units, legal 1..8.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4: instruction queue entries, power of 2, >=2.
REQ-004 SHALL have port aclk  in  1: single clock; all logic on rising edge.
REQ-005 SHALL have port srst  in  1: synchronous, active-high reset; the only reset.
REQ-006 SHALL have ports proc_valid in 1, proc_ready out 1, proc_instbus in INST_W: inbound instruction handshake.
REQ-007 SHALL have port proc_sel  in  NB_UNIT: one-hot target unit, sampled with proc_instbus.
REQ-008 SHALL have ports proc_rs1, proc_rs2, proc_rd  in  5 each, and proc_rd_wr in 1 (instruction writes rd).
REQ-009 SHALL have port flush  in  1: discards all queued, not-yet-issued instructions.
REQ-010 SHALL have ports unit_valid out NB_UNIT, unit_ready in NB_UNIT, unit_instbus out INST_W (shared, head entry).
REQ-011 SHALL have ports unit_rd_wr in NB_UNIT, unit_rd_addr in NB_UNIT*5: completion writebacks, unit i at slice [i*5+:5].
REQ-012 SHALL have ports proc_busy out 1, proc_exception out 1, queue_level out $clog2(QUEUE_DEPTH)+1.

Function
REQ-013 SHALL push {instbus, sel, rs1, rs2, rd, rd_wr} when proc_valid & proc_ready; proc_ready = !full (no pass-through when full, even if head pops).
REQ-014 SHALL make a pushed entry visible at head no earlier than next cycle; minimum push-to-unit_valid latency 1 cycle.
REQ-015 SHALL assert unit_valid[i] = head_valid & sel[i] & issue_ok & !flush; at most one bit set.
REQ-016 SHALL pop head when unit_valid[i] & unit_ready[i]; unit_valid, once high, stays high with stable unit_instbus until accepted or flush.
REQ-017 SHALL treat a head whose sel is zero or multi-hot as illegal: pop it without any unit_valid, pulse proc_exception 1 cycle.
REQ-018 SHALL, on simultaneous push and pop (not full), keep queue_level unchanged; queue pointers wrap modulo QUEUE_DEPTH.
REQ-019 SHALL on flush empty the queue next cycle, ignore a same-cycle push (proc_ready low during flush), keep scoreboard intact.
REQ-020 SHALL drive proc_busy = queue not empty OR any scoreboard bit set (registered, 1-cycle lag allowed).
REQ-021 SHALL keep unit_instbus = head data when head valid, all-zero when empty.

Reset
REQ-022 SHALL on srst clear queue pointers, queue_level=0, scoreboard=0, unit_valid=0, proc_exception=0, proc_busy=0, proc_ready=0 during reset cycle.
REQ-023 SHALL on srst mid-operation drop issued-unacknowledged state with no unit_valid in the following cycle.

Configuration
REQ-024 SHALL support macro FRISCV_SCOREBOARD_EN.
REQ-025 SHALL with FRISCV_SCOREBOARD_EN defined keep a 32-bit pending-write scoreboard: issue_ok = no pending bit on head rs1, rs2, or rd (when rd_wr); register 0 never pending.
REQ-026 SHALL with the macro set the rd bit on issue when rd_wr & rd!=0, clear bits for each unit_rd_wr[i]; same-cycle clear-then-set, set wins.
REQ-027 SHALL without FRISCV_SCOREBOARD_EN have no scoreboard: issue_ok = all unit_ready bits high (in-order, serialised), proc_busy = queue not empty OR any unit_ready low.

Verification
REQ-028 SHALL check: reset, push 4 entries with proc_sel=001 and unit_ready[0]=0 -> queue_level=4, proc_ready=0; 5th push not accepted.
REQ-029 SHALL check: push sel=010 rd=5 rd_wr=1, then sel=001 rs1=5 (macro on) -> second held until unit_rd_wr[1]=1, unit_rd_addr=5; issues next cycle.
REQ-030 SHALL check: push sel=011 -> proc_exception pulses once, no unit_valid, queue_level returns to 0.
REQ-031 SHALL check: queue holds 3 entries, assert flush with proc_valid high -> queue_level=0 next cycle, no entry accepted, scoreboard bits unchanged.
REQ-032 SHALL check: full queue, unit_ready=1 continuous, proc_valid=1 for 3*QUEUE_DEPTH cycles -> all instructions issued in order, pointer wrap-around correct.
REQ-033 SHALL check: srst asserted while unit_valid[2]=1 and unit_ready[2]=0 -> next cycle unit_valid=0, queue_level=0, proc_busy=0.

Source files
------------

// File: rtl/friscv_dispatcher.sv
// friscv_dispatcher: in-order instruction queue that hands one instruction at a
// time to one of NB_UNIT execution units selected by a one-hot tag.
//
// Configuration macro: FRISCV_SCOREBOARD_EN
//   defined   -> a 32-entry pending-write scoreboard lets the head issue as soon
//                as none of its registers is waiting for a writeback.
//   undefined -> no scoreboard; the head issues only when every unit is ready,
//                which serialises execution completely.
module friscv_dispatcher #(
    parameter int INST_W      = 128,
    parameter int NB_UNIT     = 3,
    parameter int QUEUE_DEPTH = 4
)(
    input  logic                           aclk,
    input  logic                           srst,
    // inbound instruction channel
    input  logic                           proc_valid,
    output logic                           proc_ready,
    input  logic [INST_W-1:0]              proc_instbus,
    input  logic [NB_UNIT-1:0]             proc_sel,
    input  logic [4:0]                     proc_rs1,
    input  logic [4:0]                     proc_rs2,
    input  logic [4:0]                     proc_rd,
    input  logic                           proc_rd_wr,
    input  logic                           flush,
    // execution unit side
    output logic [NB_UNIT-1:0]             unit_valid,
    input  logic [NB_UNIT-1:0]             unit_ready,
    output logic [INST_W-1:0]              unit_instbus,
    input  logic [NB_UNIT-1:0]             unit_rd_wr,
    input  logic [NB_UNIT*5-1:0]           unit_rd_addr,
    // status
    output logic                           proc_busy,
    output logic                           proc_exception,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_level
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    localparam logic [PTR_W:0]     PTR_ONE = (PTR_W + 1)'(1);
    localparam logic [NB_UNIT-1:0] SEL_ONE = NB_UNIT'(1);

    // One queued instruction with everything the issue logic needs.
    typedef struct packed {
        logic [INST_W-1:0]  inst;
        logic [NB_UNIT-1:0] sel;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic               rd_wr;
    } entry_t;

    entry_t         mem [QUEUE_DEPTH];
    entry_t         head;
    entry_t         wr_entry;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // and the fill level is a plain subtraction.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;

    logic           empty;
    logic           full;
    logic           push;
    logic           pop;
    logic           head_legal;
    logic           drop_illegal;
    logic           issue_ok;
    logic           issued;
    logic           busy_next;

    assign queue_level = wr_ptr - rd_ptr;
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign head        = mem[rd_ptr[PTR_W-1:0]];

    // A slot frees only on the next edge, so a full queue never accepts even
    // if the head leaves in the same cycle; flush and reset also refuse input.
    assign proc_ready  = !srst && !flush && !full;
    assign push        = proc_valid && proc_ready;

    assign wr_entry = '{
        inst:  proc_instbus,
        sel:   proc_sel,
        rs1:   proc_rs1,
        rs2:   proc_rs2,
        rd:    proc_rd,
        rd_wr: proc_rd_wr
    };

    // Exactly one target bit set: non-zero and clearing the lowest set bit
    // leaves nothing behind.
    assign head_legal   = (head.sel != '0) && ((head.sel & (head.sel - SEL_ONE)) == '0);

    // Illegal heads are discarded without ever being offered to a unit.
    assign drop_illegal = !srst && !empty && !head_legal && !flush;

    // Offer the head to its single target unit when it is allowed to issue.
    // Once asserted the request cannot be withdrawn except by flush/reset:
    // the head only changes on a pop, and the issue condition for a given
    // head can only improve (scoreboard bits for it are set only by its own
    // issue; without the scoreboard it only asserts when the target is ready).
    always_comb begin
        // NOTE: give every combinational output a default first so no path
        // leaves it unassigned and a latch gets inferred.
        unit_valid = '0;
        if (!srst && !empty && head_legal && issue_ok && !flush)
            unit_valid = head.sel;
    end

    assign issued       = |(unit_valid & unit_ready);
    assign pop          = issued || drop_illegal;

    // The shared instruction bus always mirrors the head, zero when empty.
    assign unit_instbus = empty ? '0 : head.inst;

    // Queue pointers: push/pop advance, flush discards everything unissued.
    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Queue storage: written on an accepted push only.
    always_ff @(posedge aclk) begin
        // NOTE: the storage array has no reset; contents are only ever read
        // through a valid pointer range, so clearing them would buy nothing.
        if (push)
            mem[wr_ptr[PTR_W-1:0]] <= wr_entry;
    end

    // One-cycle exception pulse for every illegal head that gets discarded.
    always_ff @(posedge aclk) begin
        if (srst)
            proc_exception <= 1'b0;
        else
            proc_exception <= drop_illegal;
    end

`ifdef FRISCV_SCOREBOARD_EN

    logic [31:0] pending;
    logic [31:0] clr_mask;
    logic [31:0] set_mask;

    // The head may issue when none of its operands or its destination is
    // waiting for an outstanding writeback; x0 is never pending.
    assign issue_ok = !pending[head.rs1] &&
                      !pending[head.rs2] &&
                      !(head.rd_wr && pending[head.rd]);

    // Collect the registers released by completion writebacks this cycle.
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NB_UNIT; i++) begin
            if (unit_rd_wr[i])
                clr_mask[unit_rd_addr[i*5 +: 5]] = 1'b1;
        end
    end

    // Mark the destination of the instruction issuing this cycle.
    always_comb begin
        set_mask = '0;
        if (issued && head.rd_wr && (head.rd != 5'd0))
            set_mask[head.rd] = 1'b1;
    end

    // Scoreboard update: release first, then set, so a same-cycle set wins.
    // Flush leaves it untouched because in-flight instructions still complete.
    always_ff @(posedge aclk) begin
        if (srst)
            pending <= '0;
        else
            pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
    end

    assign busy_next = !empty || (|pending);

`else

    // Without a scoreboard, only issue into a completely idle back end.
    assign issue_ok  = &unit_ready;
    assign busy_next = !empty || !(&unit_ready);

    // Writeback ports and register fields only matter to the scoreboard.
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{unit_rd_wr, unit_rd_addr,
                                head.rs1, head.rs2, head.rd, head.rd_wr};

`endif

    // Registered busy flag, lagging the queue/back-end state by one cycle.
    always_ff @(posedge aclk) begin
        if (srst)
            proc_busy <= 1'b0;
        else
            proc_busy <= busy_next;
    end

endmodule

// File: tb/tb_friscv_dispatcher.sv
// tb_friscv_dispatcher: directed scenarios followed by randomized traffic.
// A queue-based reference model predicts per-cycle outputs; a separate monitor
// pops expected issues/exceptions whenever the DUT produces one.
module tb_friscv_dispatcher;

    localparam int INST_W  = 128;
    localparam int NB_UNIT = 3;
    localparam int QD      = 4;
    localparam int LVL_W   = $clog2(QD) + 1;

`ifdef FRISCV_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic                  aclk = 1'b0;
    logic                  srst;
    logic                  proc_valid;
    logic                  proc_ready;
    logic [INST_W-1:0]     proc_instbus;
    logic [NB_UNIT-1:0]    proc_sel;
    logic [4:0]            proc_rs1;
    logic [4:0]            proc_rs2;
    logic [4:0]            proc_rd;
    logic                  proc_rd_wr;
    logic                  flush;
    logic [NB_UNIT-1:0]    unit_valid;
    logic [NB_UNIT-1:0]    unit_ready;
    logic [INST_W-1:0]     unit_instbus;
    logic [NB_UNIT-1:0]    unit_rd_wr;
    logic [NB_UNIT*5-1:0]  unit_rd_addr;
    logic                  proc_busy;
    logic                  proc_exception;
    logic [LVL_W-1:0]      queue_level;

    friscv_dispatcher #(
        .INST_W      (INST_W),
        .NB_UNIT     (NB_UNIT),
        .QUEUE_DEPTH (QD)
    ) dut (
        .aclk           (aclk),
        .srst           (srst),
        .proc_valid     (proc_valid),
        .proc_ready     (proc_ready),
        .proc_instbus   (proc_instbus),
        .proc_sel       (proc_sel),
        .proc_rs1       (proc_rs1),
        .proc_rs2       (proc_rs2),
        .proc_rd        (proc_rd),
        .proc_rd_wr     (proc_rd_wr),
        .flush          (flush),
        .unit_valid     (unit_valid),
        .unit_ready     (unit_ready),
        .unit_instbus   (unit_instbus),
        .unit_rd_wr     (unit_rd_wr),
        .unit_rd_addr   (unit_rd_addr),
        .proc_busy      (proc_busy),
        .proc_exception (proc_exception),
        .queue_level    (queue_level)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [INST_W-1:0]  inst;
        logic [NB_UNIT-1:0] sel;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic               rd_wr;
    } ent_t;

    ent_t ref_q[$];     // instructions the model believes are queued
    ent_t exp_q[$];     // outputs (issue or exception) still awaited, in order
    bit   pend[32];     // model of pending register writes
    logic busy_exp;
    int   n_checks;
    int   n_pass;
    int   exc_seen;
    bit   mon_en;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_checks++;
        if (act !== exp_v)
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp_v);
        else
            n_pass++;
    endtask

    function automatic logic [INST_W-1:0] rand_inst();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_idle();
        proc_valid   = 1'b0;
        proc_sel     = '0;
        proc_rs1     = '0;
        proc_rs2     = '0;
        proc_rd      = '0;
        proc_rd_wr   = 1'b0;
        proc_instbus = '0;
        flush        = 1'b0;
        unit_rd_wr   = '0;
        unit_rd_addr = '0;
    endtask

    task automatic drive_push(input logic [NB_UNIT-1:0] sel, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic rd_wr);
        proc_valid   = 1'b1;
        proc_sel     = sel;
        proc_rs1     = rs1;
        proc_rs2     = rs2;
        proc_rd      = rd;
        proc_rd_wr   = rd_wr;
        proc_instbus = rand_inst();
    endtask

    // One clock cycle: compare settled outputs against the model at the
    // falling edge, advance the model, then return just after the rising edge.
    task automatic step();
        ent_t               h;
        ent_t               n;
        bit                 has_head;
        bit                 legal;
        bit                 ok;
        bit                 any_pend;
        bit                 pop;
        logic [NB_UNIT-1:0] exp_uv;
        logic               exp_rdy;
        logic [INST_W-1:0]  exp_bus;
        int                 nq;

        @(negedge aclk);
        has_head = (ref_q.size() != 0);
        h = '{default: '0};
        if (has_head)
            h = ref_q[0];
        legal = ($countones(h.sel) == 1);
        if (SB_EN)
            ok = !(pend[h.rs1] || pend[h.rs2] || (h.rd_wr && pend[h.rd]));
        else
            ok = &unit_ready;
        exp_uv  = (!srst && has_head && legal && ok && !flush) ? h.sel : '0;
        exp_rdy = !srst && !flush && (ref_q.size() < QD);
        exp_bus = has_head ? h.inst : '0;

        check("unit_valid",   unit_valid,   exp_uv);
        check("proc_ready",   proc_ready,   exp_rdy);
        check("unit_instbus", unit_instbus, exp_bus);
        check("queue_level",  queue_level,  ref_q.size());
        check("proc_busy",    proc_busy,    busy_exp);

        any_pend = 1'b0;
        foreach (pend[r])
            if (pend[r]) any_pend = 1'b1;
        busy_exp = srst ? 1'b0 : (has_head || (SB_EN ? any_pend : !(&unit_ready)));

        if (srst) begin
            ref_q.delete();
            exp_q.delete();
            foreach (pend[r]) pend[r] = 1'b0;
        end else begin
            for (int i = 0; i < NB_UNIT; i++)
                if (unit_rd_wr[i]) pend[unit_rd_addr[i*5 +: 5]] = 1'b0;
            if (flush) begin
                nq = ref_q.size();
                for (int k = 0; k < nq; k++)
                    void'(exp_q.pop_back());
                ref_q.delete();
            end else begin
                pop = has_head && (!legal || ((exp_uv & unit_ready) != '0));
                if (SB_EN && pop && legal && h.rd_wr && (h.rd != 5'd0))
                    pend[h.rd] = 1'b1;
                if (pop)
                    void'(ref_q.pop_front());
                if (proc_valid && exp_rdy) begin
                    n = '{inst: proc_instbus, sel: proc_sel, rs1: proc_rs1,
                          rs2: proc_rs2, rd: proc_rd, rd_wr: proc_rd_wr};
                    ref_q.push_back(n);
                    exp_q.push_back(n);
                end
            end
        end
        @(posedge aclk);
        #1;
    endtask

    // Monitor: every exception pulse and every unit handshake consumes the
    // oldest expected outcome.
    initial begin : monitor
        ent_t               e;
        logic [NB_UNIT-1:0] hs;
        forever begin
            @(negedge aclk);
            if (mon_en) begin
                if (proc_exception === 1'b1) begin
                    exc_seen++;
                    if (exp_q.size() == 0) begin
                        check("exception_spurious", proc_exception, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("exception_for_illegal", proc_exception, ($countones(e.sel) != 1));
                    end
                end
                hs = unit_valid & unit_ready;
                if (hs != '0) begin
                    if (exp_q.size() == 0) begin
                        check("issue_spurious", hs, '0);
                    end else begin
                        e = exp_q.pop_front();
                        check("issue_unit", hs, e.sel);
                        check("issue_inst", unit_instbus, e.inst);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int                 exc_before;
        int                 r;
        logic [NB_UNIT-1:0] s;

        n_checks = 0;
        n_pass   = 0;
        exc_seen = 0;
        mon_en   = 1'b0;
        busy_exp = 1'b0;
        foreach (pend[i]) pend[i] = 1'b0;
        drive_idle();
        unit_ready = '1;
        srst = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        srst   = 1'b0;
        mon_en = 1'b1;

        // Reset state.
        check("reset_level", queue_level, 0);
        check("reset_busy",  proc_busy,   1'b0);
        check("reset_uv",    unit_valid,  '0);
        step();

        // Fill the queue toward a stalled unit 0; the fifth push is refused.
        unit_ready = '0;
        for (int k = 0; k < 5; k++) begin
            drive_push(3'b001, 5'd0, 5'd0, 5'd0, 1'b0);
            step();
        end
        check("fill_level", queue_level, QD);
        check("fill_ready", proc_ready,  1'b0);
        drive_idle();
        step();
        unit_ready = '1;
        repeat (6) step();

        // Illegal multi-hot target: one exception, no issue, queue drains.
        exc_before = exc_seen;
        drive_push(3'b011, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        drive_idle();
        repeat (4) step();
        check("illegal_exc_count", exc_seen - exc_before, 1);
        check("illegal_level", queue_level, 0);

`ifdef FRISCV_SCOREBOARD_EN
        // Leave register 9 pending so flush can be shown not to touch it.
        drive_push(3'b001, 5'd0, 5'd0, 5'd9, 1'b1);
        step();
        drive_idle();
        step();
`endif

        // Flush with three entries queued and a push attempted alongside.
        unit_ready = '0;
        for (int k = 0; k < 3; k++) begin
            drive_push(3'b010, 5'd0, 5'd0, 5'd0, 1'b0);
            step();
        end
        check("preflush_level", queue_level, 3);
        drive_push(3'b100, 5'd0, 5'd0, 5'd0, 1'b0);
        flush = 1'b1;
        step();
        drive_idle();
        check("flush_level", queue_level, 0);
        step();
        unit_ready = '1;

`ifdef FRISCV_SCOREBOARD_EN
        // Register 9 still pending after the flush: a reader must wait.
        drive_push(3'b001, 5'd9, 5'd0, 5'd0, 1'b0);
        step();
        drive_idle();
        step();
        check("flush_sb_kept", unit_valid, '0);
        unit_rd_wr = 3'b001;
        unit_rd_addr[0 +: 5] = 5'd9;
        step();
        drive_idle();
        check("flush_sb_release", unit_valid, 3'b001);
        repeat (2) step();

        // RAW hazard: reader of x5 waits for unit 1's writeback of x5.
        drive_push(3'b010, 5'd0, 5'd0, 5'd5, 1'b1);
        step();
        drive_push(3'b001, 5'd5, 5'd0, 5'd0, 1'b0);
        step();
        drive_idle();
        repeat (2) step();
        check("raw_held", unit_valid, '0);
        unit_rd_wr = 3'b010;
        unit_rd_addr[5 +: 5] = 5'd5;
        step();
        drive_idle();
        check("raw_issue", unit_valid, 3'b001);
        repeat (2) step();
`endif

        // Full queue, all units ready, continuous input for 3*depth cycles.
        unit_ready = '0;
        for (int k = 0; k < QD; k++) begin
            drive_push(NB_UNIT'(1) << $urandom_range(0, NB_UNIT-1), 5'd0, 5'd0, 5'd0, 1'b0);
            step();
        end
        unit_ready = '1;
        for (int k = 0; k < 3*QD; k++) begin
            drive_push(NB_UNIT'(1) << $urandom_range(0, NB_UNIT-1), 5'd0, 5'd0, 5'd0, 1'b0);
            step();
        end
        drive_idle();
        repeat (QD + 2) step();
        check("stream_level", queue_level, 0);

        // Reset while an instruction for unit 2 waits on a stalled unit.
        unit_ready = 3'b011;
        drive_push(3'b100, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        drive_idle();
        step();
        check("prereset_uv2", unit_valid[2], SB_EN);
        srst = 1'b1;
        step();
        srst = 1'b0;
        check("postreset_uv",    unit_valid,  '0);
        check("postreset_level", queue_level, 0);
        check("postreset_busy",  proc_busy,   1'b0);
        step();
        unit_ready = '1;
        step();

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      s = '0;
            else if (r == 1) s = 3'b011 << $urandom_range(0, 1);
            else             s = NB_UNIT'(1) << $urandom_range(0, NB_UNIT-1);
            drive_push(s, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            proc_valid = 1'($urandom_range(0, 1));
            for (int i = 0; i < NB_UNIT; i++) begin
                unit_ready[i] = ($urandom_range(0, 3) != 0);
                unit_rd_wr[i] = ($urandom_range(0, 2) == 0);
                unit_rd_addr[i*5 +: 5] = 5'($urandom_range(0, 7));
            end
            flush = ($urandom_range(0, 24) == 0);
            step();
        end

        // Drain: everything ready, sweep writebacks over all registers.
        drive_idle();
        unit_ready = '1;
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < NB_UNIT; i++) begin
                unit_rd_wr[i] = 1'b1;
                unit_rd_addr[i*5 +: 5] = 5'((c*NB_UNIT + i) % 32);
            end
            step();
        end
        drive_idle();
        repeat (3) step();
        check("drain_level", queue_level, 0);
        check("drain_outstanding", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
